md_unit: RTL and testbench

//   Multi-cycle multiply/divide unit for the P6 pipelined MIPS core, sitting beside the ALU in EX.

---
 rtl/md_defs.sv | 24 ++
 rtl/md_arith.sv | 58 +++++
 rtl/md_unit.sv | 114 +++++++++++
 tb/tb_md_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/md_defs.sv
// Shared definitions for the multiply/divide unit and the hazard logic that stalls on it.
package md_defs;

    // Operation codes presented on the op input.
    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    // Sequencer states.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    // Default busy lengths, also used by hazard control to size its stall.
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

endpackage : md_defs

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
module md_arith
    import md_defs::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] hi_n_o,
    output logic [31:0] lo_n_o,
    output logic        div0_o
);

    logic [63:0] a_sx;
    logic [63:0] b_sx;
    logic [63:0] a_zx;
    logic [63:0] b_zx;

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign a_sx = {{32{a_i[31]}}, a_i};
    assign b_sx = {{32{b_i[31]}}, b_i};
    assign a_zx = {32'b0, a_i};
    assign b_zx = {32'b0, b_i};

    // Select the 64-bit result for the latched operation; flag division by zero.
    always_comb begin
        // NOTE: every output is defaulted first so no path through the case infers a latch.
        hi_n_o = '0;
        lo_n_o = '0;
        div0_o = 1'b0;
        case (op_i)
            MD_MULT:  {hi_n_o, lo_n_o} = a_sx * b_sx;
            MD_MULTU: {hi_n_o, lo_n_o} = a_zx * b_zx;
            MD_DIV: begin
                if (b_i == '0) begin
                    div0_o = 1'b1;
                end else if (a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF) begin
                    // Most-negative / -1 overflows; wrap to the dividend, no trap.
                    lo_n_o = 32'h8000_0000;
                    hi_n_o = '0;
                end else begin
                    // Signed / and % truncate toward zero; remainder takes the dividend's sign.
                    lo_n_o = $unsigned($signed(a_i) / $signed(b_i));
                    hi_n_o = $unsigned($signed(a_i) % $signed(b_i));
                end
            end
            MD_DIVU: begin
                if (b_i == '0) begin
                    div0_o = 1'b1;
                end else begin
                    lo_n_o = a_i / b_i;
                    hi_n_o = a_i % b_i;
                end
            end
            default: ;
        endcase
    end

endmodule : md_arith

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO; busy stalls later MD instructions.
module md_unit #(
    parameter int unsigned MULT_CYCLES = md_defs::MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = md_defs::DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import md_defs::*;

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    md_op_e             op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [31:0]        hi_n;
    logic [31:0]        lo_n;
    logic               div0;
    logic               last_cycle;
    logic               accept;

    md_arith u_arith (
        .op_i   (op_q),
        .a_i    (a_q),
        .b_i    (b_q),
        .hi_n_o (hi_n),
        .lo_n_o (lo_n),
        .div0_o (div0)
    );

    // A new start is taken when idle or on the final busy cycle, so back-to-back ops have no gap.
    assign last_cycle = (state_q == S_RUN) && (cnt_q == '0);
    assign accept     = start && ((state_q == S_IDLE) || last_cycle);

    // Next-state logic: count down the run, commit the result, launch or move to HI/LO.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (state_q == S_RUN) begin
            if (cnt_q == '0) begin
                state_d = S_IDLE;
                // Divide by zero leaves HI/LO untouched.
                if (!div0) begin
                    hi_d = hi_n;
                    lo_d = lo_n;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        if (accept) begin
            case (op)
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                    state_d = S_RUN;
                    op_d    = md_op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = (op == MD_MULT || op == MD_MULTU) ? CNT_W'(MULT_CYCLES - 1)
                                                                : CNT_W'(DIV_CYCLES - 1);
                end
                MD_MTHI: hi_d = a;
                MD_MTLO: lo_d = a;
                default: ;
            endcase
        end
    end

    // State and data registers with synchronous reset; reset aborts any run in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule : md_unit

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;
    import md_defs::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    md_unit dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge with the given op and operands.
    task automatic launch(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
    endtask

    // Count busy cycles until busy drops, bounded so a stuck DUT cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b hi=%h lo=%h, expected busy=0 hi=0 lo=0", busy, hi, lo);
        end
    endtask

    task automatic run_and_check(input string name, input logic [2:0] o,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 input int exp_cyc, input logic [31:0] exp_hi,
                                 input logic [31:0] exp_lo);
        int n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        old_hi = hi;
        old_lo = lo;
        launch(o, av, bv);
        checks++;
        if (hi !== old_hi || lo !== old_lo) begin
            errors++;
            $display("FAIL %s_hold: hi=%h lo=%h during busy, expected hi=%h lo=%h",
                     name, hi, lo, old_hi, old_lo);
        end
        wait_idle(n);
        checks++;
        if (n != exp_cyc) begin
            errors++;
            $display("FAIL %s_busy: busy lasted %0d cycles, expected %0d", name, n, exp_cyc);
        end
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            errors++;
            $display("FAIL %s_result: hi=%h lo=%h, expected hi=%h lo=%h",
                     name, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_divu();
        run_and_check("divu_15_4", MD_DIVU, 32'h0000_000F, 32'h4, 10, 32'h3, 32'h3);
    endtask

    task automatic test_multu();
        run_and_check("multu_15_4", MD_MULTU, 32'h0000_000F, 32'h4, 5, 32'h0, 32'h3C);
        run_and_check("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,
                      32'hFFFF_FFFE, 32'h0000_0001);
    endtask

    task automatic test_signed();
        run_and_check("div_m15_4", MD_DIV, 32'hFFFF_FFF1, 32'h4, 10, 32'hFFFF_FFFD, 32'hFFFF_FFFD);
        run_and_check("mult_m1_m1", MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'h0, 32'h1);
        run_and_check("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_and_check("div_m7_m2", MD_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 10, 32'hFFFF_FFFF, 32'h3);
    endtask

    task automatic test_move_and_div0();
        launch(MD_MTHI, 32'h1234_5678, 32'h0);
        checks++;
        if (hi !== 32'h1234_5678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi: hi=%h busy=%b, expected hi=12345678 busy=0", hi, busy);
        end
        launch(MD_MTLO, 32'h9ABC_DEF0, 32'h0);
        checks++;
        if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: hi=%h lo=%h busy=%b, expected hi=12345678 lo=9abcdef0 busy=0",
                     hi, lo, busy);
        end
        launch(3'd6, 32'hDEAD_BEEF, 32'h1);
        checks++;
        if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL undef_op: busy=%b hi=%h lo=%h, expected busy=0 hi=12345678 lo=9abcdef0",
                     busy, hi, lo);
        end
        run_and_check("divu_by0", MD_DIVU, 32'h0000_0064, 32'h0, 10, 32'h1234_5678, 32'h9ABC_DEF0);
    endtask

    task automatic test_ignore_and_reset();
        int n;
        // mult 0x10000 * 0x30000 = 0x3_0000_0000
        launch(MD_MULT, 32'h0001_0000, 32'h0003_0000);
        tick();
        launch(MD_MTHI, 32'hDEAD_BEEF, 32'h0);
        checks++;
        if (hi !== 32'h1234_5678 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mthi_ignored: hi=%h busy=%b, expected hi=12345678 busy=1", hi, busy);
        end
        wait_idle(n);
        checks++;
        if (n != 3 || hi !== 32'h3 || lo !== 32'h0) begin
            errors++;
            $display("FAIL mult_after_ignore: remaining=%0d hi=%h lo=%h, expected 3 hi=3 lo=0",
                     n, hi, lo);
        end
        launch(MD_DIVU, 32'd100, 32'd7);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_div: busy=%b hi=%h lo=%h, expected busy=0 hi=0 lo=0",
                     busy, hi, lo);
        end
        repeat (10) tick();
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_no_commit: busy=%b hi=%h lo=%h, expected busy=0 hi=0 lo=0",
                     busy, hi, lo);
        end
    endtask

    task automatic test_back_to_back();
        int total;
        int n;
        total = 0;
        // divu 100/7 -> q=14 r=2; then divu 1000/7 -> q=142 r=6
        launch(MD_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 9; i++) begin
            if (busy === 1'b1) total++;
            tick();
        end
        if (busy === 1'b1) total++;
        launch(MD_DIVU, 32'd1000, 32'd7);
        checks++;
        if (busy !== 1'b1 || hi !== 32'd2 || lo !== 32'd14) begin
            errors++;
            $display("FAIL b2b_first: busy=%b hi=%h lo=%h, expected busy=1 hi=2 lo=e",
                     busy, hi, lo);
        end
        wait_idle(n);
        total += n;
        checks++;
        if (total != 20) begin
            errors++;
            $display("FAIL b2b_busy: continuous busy=%0d cycles, expected 20", total);
        end
        checks++;
        if (hi !== 32'd6 || lo !== 32'd142) begin
            errors++;
            $display("FAIL b2b_second: hi=%h lo=%h, expected hi=6 lo=8e", hi, lo);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        start  = 1'b0;
        op     = 3'd0;
        a      = '0;
        b      = '0;
        test_reset();
        test_divu();
        test_multu();
        test_signed();
        test_move_and_div0();
        test_ignore_and_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_md_unit
